// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB TX flexible counter.
// Holds the terminal-mode encoding and the count-direction constants.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // The reserved encoding is folded into WRAP so it never stalls the counter.
    function automatic logic is_wrap_mode(input mode_e m);
        return (m == MODE_WRAP) || (m == MODE_RSVD);
    endfunction

endpackage

// File: rtl/usb_tx_flex_counter.sv
// Up/down counter with programmable step, terminal value and terminal mode.
// All outputs are registered; rollover_flag is derived from the next count.
module usb_tx_flex_counter
    import usb_tx_pkg::*;
#(
    parameter int SIZE     = 8,
    parameter int INC_SIZE = 1
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            clear,
    input  logic            load,
    input  logic [SIZE-1:0] load_val,
    input  logic            count_enable,
    input  logic            dir,
    input  logic [1:0]      mode,
    input  logic [SIZE-1:0] rollover_val,
    output logic [SIZE-1:0] count_out,
    output logic            rollover_flag,
    output logic            wrap_pulse,
    output logic            done
);

    localparam logic [SIZE:0] INC_W = (SIZE+1)'(INC_SIZE);

    logic [SIZE-1:0] r_count;
    logic            r_flag;
    logic            r_wrap;
    logic            r_done;

    logic [SIZE-1:0] w_next_count;
    logic            w_next_wrap;
    logic            w_next_done;
    logic            w_next_flag;
    logic [SIZE:0]   w_sum;
    logic [SIZE:0]   w_cnt_ext;
    logic [SIZE:0]   w_rv_ext;
    logic [SIZE-1:0] w_term;
    logic            w_blocked;
    mode_e           w_mode;

    assign w_mode    = mode_e'(mode);
    assign w_cnt_ext = {1'b0, r_count};
    assign w_rv_ext  = {1'b0, rollover_val};
    // One bit of headroom so a large step past the terminal cannot alias low.
    assign w_sum     = w_cnt_ext + INC_W;
    assign w_blocked = r_done && (w_mode == MODE_ONESHOT);
    assign w_term    = (dir == DIR_DOWN) ? '0 : rollover_val;

    always_comb begin
        w_next_count = r_count;
        w_next_wrap  = 1'b0;
        w_next_done  = r_done;
        if (clear) begin
            w_next_count = (dir == DIR_DOWN) ? rollover_val : '0;
            w_next_done  = 1'b0;
        end else if (load) begin
            w_next_count = load_val;
            w_next_done  = 1'b0;
        end else if (count_enable && !w_blocked) begin
            if (dir == DIR_UP) begin
                if (r_count < rollover_val) begin
                    w_next_count = (w_sum > w_rv_ext) ? rollover_val : w_sum[SIZE-1:0];
                end else if (is_wrap_mode(w_mode)) begin
                    w_next_count = '0;
                    w_next_wrap  = 1'b1;
                end else if (w_mode == MODE_ONESHOT) begin
                    w_next_done  = 1'b1;
                end
            end else begin
                if (r_count != '0) begin
                    w_next_count = (w_cnt_ext > INC_W) ? (r_count - INC_W[SIZE-1:0]) : '0;
                end else if (is_wrap_mode(w_mode)) begin
                    w_next_count = rollover_val;
                    w_next_wrap  = 1'b1;
                end else if (w_mode == MODE_ONESHOT) begin
                    w_next_done  = 1'b1;
                end
            end
        end
        w_next_flag = (w_next_count == w_term);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_count <= '0;
            r_flag  <= 1'b0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_flag  <= w_next_flag;
            r_wrap  <= w_next_wrap;
            r_done  <= w_next_done;
        end
    end

    assign count_out     = r_count;
    assign rollover_flag = r_flag;
    assign wrap_pulse    = r_wrap;
    assign done          = r_done;

endmodule
